// File: rtl/wave_oscillator_if.sv
// rtl/wave_oscillator_if.sv - Control and sample bus of one oscillator voice; duty exists only with PULSE_WIDTH_EN.
interface wave_oscillator_if #(
    parameter int OUT_WIDTH  = 8,
    parameter int FREQ_WIDTH = 8
);
    logic                  enable;
    logic [FREQ_WIDTH-1:0] frequency_control;
    logic [1:0]            mode;
`ifdef PULSE_WIDTH_EN
    logic [OUT_WIDTH-1:0]  duty;
`endif
    logic [OUT_WIDTH-1:0]  sample_out;
    logic                  sample_valid;
    logic                  wrap;

`ifdef PULSE_WIDTH_EN
    modport master (output enable, frequency_control, mode, duty,
                    input  sample_out, sample_valid, wrap);
    modport slave  (input  enable, frequency_control, mode, duty,
                    output sample_out, sample_valid, wrap);
`else
    modport master (output enable, frequency_control, mode,
                    input  sample_out, sample_valid, wrap);
    modport slave  (input  enable, frequency_control, mode,
                    output sample_out, sample_valid, wrap);
`endif
endinterface

// File: rtl/wave_oscillator.sv
// rtl/wave_oscillator.sv - Phase-accumulator oscillator (saw/square/triangle/rev-saw); PULSE_WIDTH_EN adds a duty threshold.
module wave_oscillator #(
    parameter int OUT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int FREQ_WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    wave_oscillator_if.slave bus
);
    logic [ACC_WIDTH-1:0] phase_q, phase_d;
    logic [OUT_WIDTH-1:0] sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;

    logic [ACC_WIDTH:0]   sum;
    logic [OUT_WIDTH-1:0] p;
    logic [OUT_WIDTH:0]   t;
    logic [OUT_WIDTH-1:0] th;
    logic [OUT_WIDTH-1:0] wave;

    always_comb begin
        // One extra bit on the add captures the carry that drives wrap.
        sum = {1'b0, phase_q} + {{(ACC_WIDTH + 1 - FREQ_WIDTH){1'b0}}, bus.frequency_control};
        p   = phase_q[ACC_WIDTH-1 -: OUT_WIDTH];
        t   = phase_q[ACC_WIDTH-1 -: OUT_WIDTH+1];
`ifdef PULSE_WIDTH_EN
        th  = bus.duty;
`else
        th  = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`endif
        case (bus.mode)
            2'b00:   wave = p;
            2'b01:   wave = (p < th) ? {OUT_WIDTH{1'b1}} : {OUT_WIDTH{1'b0}};
            2'b10:   wave = t[OUT_WIDTH] ? ~t[OUT_WIDTH-1:0] : t[OUT_WIDTH-1:0];
            default: wave = ~p;
        endcase

        phase_d  = phase_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        if (bus.enable) begin
            phase_d  = sum[ACC_WIDTH-1:0];
            sample_d = wave;
            valid_d  = 1'b1;
            wrap_d   = sum[ACC_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.wrap         = wrap_q;
endmodule
